// File: rtl/stream_demux_pkg.sv
// Shared constants for the stream demultiplexer slice.
//   CTRL_DEFAULT / DATA_WIDTH_DEFAULT : default select and payload widths
//   WRAP_CTRL / WRAP_DATA_WIDTH       : fixed widths of the lint/synthesis wrapper
package stream_demux_pkg;

  localparam int CTRL_DEFAULT       = 2;
  localparam int DATA_WIDTH_DEFAULT = 1;
  localparam int WRAP_CTRL          = 3;
  localparam int WRAP_DATA_WIDTH    = 8;

endpackage

// File: rtl/stream_demux_wrap.sv
// Fixed-width instance of stream_demux (8 channels, 8-bit payload) used as a
// standalone synthesis/lint target. Ports mirror stream_demux.
module stream_demux_wrap
  import stream_demux_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       inp_valid,
  output logic                       inp_ready,
  input  logic [WRAP_DATA_WIDTH-1:0] inp,
  input  logic [WRAP_CTRL-1:0]       ctrl,
  output logic [WRAP_DATA_WIDTH-1:0] out [2**WRAP_CTRL],
  output logic [2**WRAP_CTRL-1:0]    out_valid,
  input  logic [2**WRAP_CTRL-1:0]    out_ready,
  output logic [WRAP_CTRL:0]         pending
);

  stream_demux #(
    .CTRL      (WRAP_CTRL),
    .DATA_WIDTH(WRAP_DATA_WIDTH)
  ) u_demux (
    .clk      (clk),
    .reset    (reset),
    .inp_valid(inp_valid),
    .inp_ready(inp_ready),
    .inp      (inp),
    .ctrl     (ctrl),
    .out      (out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pending  (pending)
  );

endmodule

// File: rtl/stream_reg.sv
// Single-entry stream register (one payload word plus a full flag).
//   clk, reset : rising-edge clock, synchronous active-high reset
//   load, data : write data and mark full at the next edge
//   drain      : downstream accept; empties the entry when full and not reloaded
//   valid, out : full flag and stored payload (zero while empty)
module stream_reg
  import stream_demux_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  drain,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] out
);

  logic                  full_q, full_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // A reload in the same cycle as a drain keeps the entry full with new data.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (full_q && drain) full_d = 1'b0;
    if (load) begin
      full_d = 1'b1;
      data_d = data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign valid = full_q;
  assign out   = full_q ? data_q : '0;

endmodule

// File: rtl/stream_demux.sv
// Stream demultiplexer: routes each upstream beat to channel ctrl, with one
// independent single-entry register per channel.
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   inp_valid/inp_ready  : upstream handshake; inp payload, ctrl destination
//   out[N]/out_valid[N]  : per-channel payload and beat-present flags
//   out_ready[N]         : per-channel downstream accept
//   pending              : number of channels currently holding a beat
`ifndef STREAM_DEMUX_SV
`define STREAM_DEMUX_SV
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int CTRL       = CTRL_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inp_valid,
  output logic                  inp_ready,
  input  logic [DATA_WIDTH-1:0] inp,
  input  logic [CTRL-1:0]       ctrl,
  output logic [DATA_WIDTH-1:0] out [2**CTRL],
  output logic [2**CTRL-1:0]    out_valid,
  input  logic [2**CTRL-1:0]    out_ready,
  output logic [CTRL:0]         pending
);

  localparam int unsigned N  = 2**CTRL;
  localparam int          PW = CTRL + 1;

  logic [N-1:0] load;

  // Ready depends only on the selected channel's state, never on inp_valid.
  always_comb begin
    load      = '0;
    inp_ready = !out_valid[ctrl] | out_ready[ctrl];
    if (inp_valid && inp_ready) load[ctrl] = 1'b1;
  end

  for (genvar g = 0; g < N; g++) begin : g_chan
    stream_reg #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_reg (
      .clk  (clk),
      .reset(reset),
      .load (load[g]),
      .data (inp),
      .drain(out_ready[g]),
      .valid(out_valid[g]),
      .out  (out[g])
    );
  end

  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pending = pending + PW'(out_valid[i]);
    end
  end

endmodule
`endif

// File: tb/tb_stream_demux.sv
module tb_stream_demux;

  logic       clk;
  logic       reset;
  logic       inp_valid;
  logic       inp_ready;
  logic [7:0] inp;
  logic [1:0] ctrl;
  logic [7:0] out_s [4];
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [2:0] pending;

  int checks = 0;
  int errors = 0;

  stream_demux #(
    .CTRL      (2),
    .DATA_WIDTH(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .inp_valid(inp_valid),
    .inp_ready(inp_ready),
    .inp      (inp),
    .ctrl     (ctrl),
    .out      (out_s),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pending  (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic        v;
    logic [1:0]  c;
    logic [7:0]  d;
    logic [3:0]  rdy;
    logic        e_ready;
    logic [3:0]  e_valid;
    logic [31:0] e_out;
    logic [2:0]  e_pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic v, logic [1:0] c, logic [7:0] d,
                              logic [3:0] rdy, logic e_ready, logic [3:0] e_valid,
                              logic [31:0] e_out, logic [2:0] e_pend);
    vec_t r;
    r.rst = rst; r.v = v; r.c = c; r.d = d; r.rdy = rdy;
    r.e_ready = e_ready; r.e_valid = e_valid; r.e_out = e_out; r.e_pend = e_pend;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] flat_out();
    return {out_s[3], out_s[2], out_s[1], out_s[0]};
  endfunction

  task automatic drive(input logic rst, input logic v, input logic [1:0] c,
                       input logic [7:0] d, input logic [3:0] rdy);
    reset = rst; inp_valid = v; ctrl = c; inp = d; out_ready = rdy;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] ev,
                           input logic [31:0] eo, input logic [2:0] ep);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    chk({tag, ".out"}, flat_out(), eo);
    chk({tag, ".pending"}, 32'(pending), 32'(ep));
  endtask

  initial begin
    drive(1'b1, 1'b1, 2'd1, 8'h55, 4'h0);

    // Reset held two cycles with a beat presented.
    tick();
    tick();
    chk_state("reset", 4'h0, 32'h0, 3'd0);
    #1 chk("reset.inp_ready", 32'(inp_ready), 32'd1);
    drive(1'b0, 1'b0, 2'd1, 8'h55, 4'h0);
    tick();
    chk_state("post_reset", 4'h0, 32'h0, 3'd0);

    // Routing
    vecs.push_back(mk(0, 1, 2'd0, 8'hA1, 4'hF, 1, 4'b0001, 32'h0000_00A1, 3'd1));
    vecs.push_back(mk(0, 1, 2'd3, 8'hB2, 4'hF, 1, 4'b1000, 32'hB200_0000, 3'd1));
    vecs.push_back(mk(0, 0, 2'd0, 8'hFF, 4'hF, 1, 4'b0000, 32'h0000_0000, 3'd0));
    // Throughput on ch2
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(0, 1, 2'd2, 8'(k), 4'hF, 1, 4'b0100, {8'h00, 8'(k), 16'h0000}, 3'd1));
    vecs.push_back(mk(0, 0, 2'd2, 8'h00, 4'hF, 1, 4'b0000, 32'h0, 3'd0));
    // Pending fill with all outputs stalled
    vecs.push_back(mk(0, 1, 2'd0, 8'h10, 4'h0, 1, 4'b0001, 32'h0000_0010, 3'd1));
    vecs.push_back(mk(0, 1, 2'd1, 8'h20, 4'h0, 1, 4'b0011, 32'h0000_2010, 3'd2));
    vecs.push_back(mk(0, 1, 2'd2, 8'h30, 4'h0, 1, 4'b0111, 32'h0030_2010, 3'd3));
    vecs.push_back(mk(0, 1, 2'd3, 8'h40, 4'h0, 1, 4'b1111, 32'h4030_2010, 3'd4));
    vecs.push_back(mk(0, 1, 2'd0, 8'h99, 4'h0, 0, 4'b1111, 32'h4030_2010, 3'd4));
    vecs.push_back(mk(0, 0, 2'd0, 8'h99, 4'hF, 1, 4'b0000, 32'h0, 3'd0));

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].rst, vecs[i].v, vecs[i].c, vecs[i].d, vecs[i].rdy);
      #1 chk({tag, ".inp_ready"}, 32'(inp_ready), 32'(vecs[i].e_ready));
      tick();
      chk_state(tag, vecs[i].e_valid, vecs[i].e_out, vecs[i].e_pend);
    end

    // Back-pressure on ch1
    drive(1'b0, 1'b1, 2'd1, 8'h11, 4'b1101);
    #1 chk("bp.ready_first", 32'(inp_ready), 32'd1);
    tick();
    chk_state("bp.first", 4'b0010, 32'h0000_1100, 3'd1);
    inp = 8'h22;
    #1 chk("bp.ready_blocked", 32'(inp_ready), 32'd0);
    tick();
    chk_state("bp.hold1", 4'b0010, 32'h0000_1100, 3'd1);
    tick();
    chk_state("bp.hold2", 4'b0010, 32'h0000_1100, 3'd1);
    out_ready = 4'hF;
    #1 chk("bp.ready_release", 32'(inp_ready), 32'd1);
    tick();
    chk_state("bp.second", 4'b0010, 32'h0000_2200, 3'd1);
    inp_valid = 1'b0;
    tick();
    chk_state("bp.drained", 4'b0000, 32'h0, 3'd0);

    // Mid-operation reset with ch0 and ch2 full; beat in reset cycle dropped
    drive(1'b0, 1'b1, 2'd0, 8'hC0, 4'h0);
    tick();
    drive(1'b0, 1'b1, 2'd2, 8'hC2, 4'h0);
    tick();
    chk_state("mid.full", 4'b0101, 32'h00C2_00C0, 3'd2);
    drive(1'b1, 1'b1, 2'd1, 8'hEE, 4'h0);
    tick();
    chk_state("mid.reset", 4'b0000, 32'h0, 3'd0);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'hF);
    #1 chk("mid.inp_ready", 32'(inp_ready), 32'd1);
    tick();
    chk_state("mid.after", 4'b0000, 32'h0, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 SHALL have parameter CTRL, default 2: select width; channel count N = 2**CTRL.
REQ-002 SHALL have parameter DATA_WIDTH, default 1: payload width per channel.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port inp_valid  input  1  upstream beat present.
REQ-006 SHALL have port inp_ready  output  1  beat accepted this cycle when high with inp_valid.
REQ-007 SHALL have port inp  input  DATA_WIDTH  upstream payload.
REQ-008 SHALL have port ctrl  input  CTRL  destination channel index, sampled with the beat.
REQ-009 SHALL have port out  output  DATA_WIDTH x N (unpacked array [N])  per-channel payload.
REQ-010 SHALL have port out_valid  output  N  per-channel beat present.
REQ-011 SHALL have port out_ready  input  N  per-channel downstream accept.
REQ-012 SHALL have port pending  output  CTRL+1  number of channels currently holding a beat.

Function
REQ-013 SHALL hold one independent single-entry register (data + full flag) per channel.
REQ-014 SHALL assert inp_ready = !full[ctrl] | out_ready[ctrl], combinationally from current state and ctrl only (never from inp_valid).
REQ-015 SHALL transfer on inp_valid & inp_ready: channel ctrl loads inp and sets full at the next edge; latency input-to-out_valid exactly 1 cycle.
REQ-016 SHALL drive out_valid[i] = full[i]; out[i] = stored data when full[i], else all-zero.
REQ-017 SHALL clear full[i] on out_valid[i] & out_ready[i] unless channel i is reloaded in the same cycle.
REQ-018 SHALL, on simultaneous drain and load of the same channel, keep full[i]=1 and present the new data next cycle (full throughput, 1 beat/cycle per channel).
REQ-019 SHALL hold out[i] stable while out_valid[i] & !out_ready[i] (no data change under back-pressure).
REQ-020 SHALL leave all non-selected channels unaffected by a load; drains on any subset of channels may occur in the same cycle as a load to another.
REQ-021 SHALL compute pending as the population count of the registered full vector (reflects current cycle's out_valid), range 0..N.
REQ-022 SHALL ignore ctrl and inp when inp_valid is low; inp_ready may still be high.

Reset
REQ-023 SHALL on reset clear all full flags and data registers: out_valid=0, out=0 on all channels, pending=0 in the cycle after reset is sampled.
REQ-024 SHALL drop any held or in-flight beat when reset asserts mid-operation; a beat presented in the reset cycle is not accepted.
REQ-025 SHALL keep inp_ready combinationally consistent with the cleared state during and after reset (high after reset, as all channels empty).

Structure
REQ-026 SHALL instantiate one sub-module stream_reg (DATA_WIDTH param; load, data, drain, valid, out) per channel via generate loop.
REQ-027 SHALL keep channel-count arithmetic local; no shared package needed beyond existing utility includes; file guarded by include-guard macro.
REQ-028 SHALL provide a fixed-parameter test wrapper (CTRL=3, DATA_WIDTH=8) for synthesis/lint.

Verification (CTRL=2, DATA_WIDTH=8)
REQ-029 SHALL check reset: reset=1 two cycles with inp_valid=1 -> out_valid=0000, out all 0x00, pending=0, no beat appears after release.
REQ-030 SHALL check routing: beats 0xA1/ctrl=0, 0xB2/ctrl=3, all out_ready=1 -> out[0]=0xA1 valid one cycle after acceptance, then out[3]=0xB2; other channels stay 0x00/invalid.
REQ-031 SHALL check back-pressure: out_ready[1]=0, send 0x11 then 0x22 to ch1 -> first accepted, inp_ready=0 on second; out[1]=0x11 stable; raise out_ready[1] -> 0x22 accepted same cycle, appears next cycle.
REQ-032 SHALL check throughput: continuous beats 0x01..0x08 to ch2 with out_ready[2]=1 -> inp_ready stays 1, out[2] shows 0x01..0x08 on consecutive cycles.
REQ-033 SHALL check pending: stall all out_ready, fill ch0..ch3 -> pending 1,2,3,4; release out_ready=1111 -> pending=0 next cycle.
REQ-034 SHALL check mid-operation reset: ch0 and ch2 full, assert reset one cycle -> both cleared, pending=0, old data never emitted.
